// File: rtl/bms_pkg.sv
// Shared definitions for the battery-management sensing blocks: default timing
// parameters and the moisture front-end sequencer state encoding.
package bms_pkg;

  localparam int unsigned ExcPeriodDef = 8;
  localparam int unsigned SettleCycDef = 4;
  localparam int unsigned DebWetDef    = 3;
  localparam int unsigned DebDryDef    = 5;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StSettle,
    StSample
  } fe_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/moisture_debounce.sv
// Wet/dry sample debouncer with hysteresis: sets after DEB_WET wet samples in a
// row, clears after DEB_DRY dry samples in a row, otherwise holds.
module moisture_debounce
  import bms_pkg::*;
#(
  parameter int unsigned DEB_WET = DebWetDef,
  parameter int unsigned DEB_DRY = DebDryDef
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic sample,
  input  logic wet,
  output logic moisture
);

  localparam int unsigned WetW = $clog2(DEB_WET + 1);
  localparam int unsigned DryW = $clog2(DEB_DRY + 1);
  localparam logic [WetW-1:0] WetMax = WetW'(DEB_WET);
  localparam logic [DryW-1:0] DryMax = DryW'(DEB_DRY);

  logic [WetW-1:0] wet_cnt_q, wet_cnt_d;
  logic [DryW-1:0] dry_cnt_q, dry_cnt_d;
  logic            moisture_q, moisture_d;

  // Clearing the counters leaves the flag itself untouched.
  always_comb begin
    wet_cnt_d  = wet_cnt_q;
    dry_cnt_d  = dry_cnt_q;
    moisture_d = moisture_q;
    if (clear) begin
      wet_cnt_d = '0;
      dry_cnt_d = '0;
    end else if (sample) begin
      if (wet) begin
        dry_cnt_d = '0;
        if (wet_cnt_q != WetMax) wet_cnt_d = wet_cnt_q + 1'b1;
        if (wet_cnt_d == WetMax) moisture_d = 1'b1;
      end else begin
        wet_cnt_d = '0;
        if (dry_cnt_q != DryMax) dry_cnt_d = dry_cnt_q + 1'b1;
        if (dry_cnt_d == DryMax) moisture_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wet_cnt_q  <= '0;
      dry_cnt_q  <= '0;
      moisture_q <= 1'b0;
    end else begin
      wet_cnt_q  <= wet_cnt_d;
      dry_cnt_q  <= dry_cnt_d;
      moisture_q <= moisture_d;
    end
  end

  assign moisture = moisture_q;

endmodule

// File: rtl/moisture_sense_frontend.sv
// Electrode moisture sensor front end: excitation sequencer with alternating
// polarity, baseline leakage fault detection and debounced moisture flag.
module moisture_sense_frontend
  import bms_pkg::*;
#(
  parameter int unsigned EXC_PERIOD = ExcPeriodDef,
  parameter int unsigned SETTLE_CYC = SettleCycDef,
  parameter int unsigned DEB_WET    = DebWetDef,
  parameter int unsigned DEB_DRY    = DebDryDef
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic sense_in,
  output logic exc_drive,
  output logic exc_polarity,
  output logic moisture_sensor,
  output logic sample_valid,
  output logic sensor_fault
);

  localparam int unsigned PhaseW = $clog2(max_u(EXC_PERIOD, SETTLE_CYC) + 1);
  localparam logic [PhaseW-1:0] ExcLast    = PhaseW'(EXC_PERIOD - 1);
  localparam logic [PhaseW-1:0] SettleLast = PhaseW'(SETTLE_CYC - 1);

  logic sense_meta_q, sense_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sense_meta_q <= 1'b0;
      sense_s      <= 1'b0;
    end else begin
      sense_meta_q <= sense_in;
      sense_s      <= sense_meta_q;
    end
  end

  fe_state_e         state_q;
  logic [PhaseW-1:0] phase_q;
  logic              baseline_q;
  logic              prev_base_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      exc_drive    <= 1'b0;
      exc_polarity <= 1'b0;
      sample_valid <= 1'b0;
      baseline_q   <= 1'b0;
      prev_base_q  <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!enable) begin
        state_q   <= StIdle;
        phase_q   <= '0;
        exc_drive <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StWait;
            phase_q <= '0;
          end
          StWait: begin
            if (phase_q == ExcLast) begin
              baseline_q <= sense_s;
              phase_q    <= '0;
              state_q    <= StSettle;
              exc_drive  <= 1'b1;
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
          StSettle: begin
            if (phase_q == SettleLast) begin
              phase_q <= '0;
              state_q <= StSample;
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
          StSample: begin
            state_q      <= StWait;
            exc_drive    <= 1'b0;
            exc_polarity <= ~exc_polarity;
            sample_valid <= 1'b1;
            prev_base_q  <= baseline_q;
            // A conductive path with excitation off means electrode leakage.
            if (baseline_q && prev_base_q) sensor_fault <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  logic sample_stb;
  logic deb_clear;
  logic moisture_db;

  assign sample_stb = enable && (state_q == StSample);
  assign deb_clear  = !enable;

  moisture_debounce #(
    .DEB_WET(DEB_WET),
    .DEB_DRY(DEB_DRY)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .clear   (deb_clear),
    .sample  (sample_stb),
    .wet     (sense_s),
    .moisture(moisture_db)
  );

  // Fail-safe: a faulty sensor must block charging.
  assign moisture_sensor = moisture_db | sensor_fault;

endmodule

// File: tb/tb_moisture_sense_frontend.sv
// Self-checking bench for moisture_sense_frontend: directed scenarios plus
// randomized stimulus against a measurement-level reference model.
module tb_moisture_sense_frontend;

  localparam int ExcPeriod = 8;
  localparam int SettleCyc = 4;
  localparam int DebWet    = 3;
  localparam int DebDry    = 5;
  localparam int Period    = ExcPeriod + SettleCyc + 1;

  logic clk = 1'b0;
  logic reset, enable, sense_in;
  logic exc_drive, exc_polarity, moisture_sensor, sample_valid, sensor_fault;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  moisture_sense_frontend #(
    .EXC_PERIOD(ExcPeriod),
    .SETTLE_CYC(SettleCyc),
    .DEB_WET   (DebWet),
    .DEB_DRY   (DebDry)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .sense_in       (sense_in),
    .exc_drive      (exc_drive),
    .exc_polarity   (exc_polarity),
    .moisture_sensor(moisture_sensor),
    .sample_valid   (sample_valid),
    .sensor_fault   (sensor_fault)
  );

  // Reference model: position within the measurement period, plus histories
  // of completed measurement values and baselines.
  int t_ref = -1;
  bit pol_ref, valid_ref, moist_ref, fault_ref, base_pending;
  bit sd[$];
  bit samples[$];
  bit bases[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit exc_now();
    return (t_ref >= 0) && ((t_ref % Period) >= ExcPeriod);
  endfunction

  task automatic model_edge();
    bit ss;
    int p;
    bit all_wet, all_dry;
    if (reset) begin
      t_ref = -1; pol_ref = 0; valid_ref = 0; moist_ref = 0; fault_ref = 0;
      base_pending = 0;
      samples.delete(); bases.delete();
      sd = '{1'b0, 1'b0};
      return;
    end
    ss = sd[0];
    void'(sd.pop_front());
    sd.push_back(sense_in);
    valid_ref = 0;
    if (!enable) begin
      t_ref = -1;
      samples.delete();
      return;
    end
    if (t_ref < 0) begin
      t_ref = 0;
      return;
    end
    p = t_ref % Period;
    if (p == ExcPeriod - 1) base_pending = ss;
    if (p == Period - 1) begin
      valid_ref = 1;
      pol_ref = !pol_ref;
      bases.push_back(base_pending);
      if (bases.size() >= 2 && bases[bases.size()-1] && bases[bases.size()-2]) fault_ref = 1;
      samples.push_back(ss);
      all_wet = samples.size() >= DebWet;
      all_dry = samples.size() >= DebDry;
      for (int k = 0; k < DebWet && all_wet; k++)
        if (!samples[samples.size()-1-k]) all_wet = 0;
      for (int k = 0; k < DebDry && all_dry; k++)
        if (samples[samples.size()-1-k]) all_dry = 0;
      if (all_wet) moist_ref = 1;
      else if (all_dry) moist_ref = 0;
    end
    t_ref++;
  endtask

  task automatic step(input bit r, input bit en, input bit s);
    reset = r; enable = en; sense_in = s;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("exc_drive", exc_drive, exc_now());
    check("exc_polarity", exc_polarity, pol_ref);
    check("sample_valid", sample_valid, valid_ref);
    check("moisture_sensor", moisture_sensor, moist_ref | fault_ref);
    check("sensor_fault", sensor_fault, fault_ref);
  endtask

  // mode 0: dry, 1: conductive only while excited, 2: constantly conductive
  task automatic run_meas(input int mode, input int n);
    int got = 0;
    for (int i = 0; i < (n + 2) * Period && got < n; i++) begin
      step(1'b0, 1'b1, (mode == 2) ? 1'b1 : ((mode == 1) ? exc_now() : 1'b0));
      if (valid_ref) got++;
    end
  endtask

  initial begin
    int last_sv;
    int cnt;
    bit wet_flag;
    bit s;
    reset = 1'b1; enable = 1'b0; sense_in = 1'b0;
    @(negedge clk);

    // Idle sequencing with a dry electrode, pulse spacing
    step(1'b1, 1'b0, 1'b0);
    check("reset_exc", exc_drive, 0);
    check("reset_moist", moisture_sensor, 0);
    last_sv = -1;
    for (int i = 0; i < 6 * Period; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (sample_valid) begin
        if (last_sv >= 0) check("sv_spacing", i - last_sv, Period);
        last_sv = i;
      end
    end
    check("dry_moist", moisture_sensor, 0);

    // Wet debounce then dry hysteresis
    step(1'b1, 1'b0, 1'b0);
    run_meas(1, 2);
    check("wet2_moist", moisture_sensor, 0);
    run_meas(1, 1);
    check("wet3_moist", moisture_sensor, 1);
    run_meas(0, 4);
    check("dry4_moist", moisture_sensor, 1);
    run_meas(0, 1);
    check("dry5_moist", moisture_sensor, 0);

    // Interrupted wet run
    step(1'b1, 1'b0, 1'b0);
    run_meas(1, 1); run_meas(1, 1); run_meas(0, 1); run_meas(1, 1); run_meas(1, 1);
    check("wwdww_moist", moisture_sensor, 0);

    // Leakage fault is sticky across enable=0
    step(1'b1, 1'b0, 1'b0);
    run_meas(2, 1);
    check("fault1", sensor_fault, 0);
    check("fault1_moist", moisture_sensor, 0);
    run_meas(2, 1);
    check("fault2", sensor_fault, 1);
    check("fault2_moist", moisture_sensor, 1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
    check("fault_hold", sensor_fault, 1);
    check("fault_hold_moist", moisture_sensor, 1);
    step(1'b1, 1'b1, 1'b1);
    check("fault_reset", sensor_fault, 0);

    // Enable dropped during SETTLE, then full restart
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3 * Period && (t_ref % Period) != ExcPeriod + 1; i++)
      step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("drop_exc", exc_drive, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 1; i <= 30 && cnt == 0; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (exc_drive) cnt = i;
    end
    check("restart_wait", cnt, ExcPeriod + 1);

    // Reset in SETTLE with moisture asserted
    step(1'b1, 1'b0, 1'b0);
    run_meas(1, 3);
    for (int i = 0; i < 3 * Period && (t_ref % Period) != ExcPeriod + 2; i++)
      step(1'b0, 1'b1, exc_now());
    check("pre_reset_moist", moisture_sensor, 1);
    step(1'b1, 1'b1, 1'b1);
    check("rst_exc", exc_drive, 0);
    check("rst_pol", exc_polarity, 0);
    check("rst_moist", moisture_sensor, 0);
    check("rst_valid", sample_valid, 0);

    // Randomized run
    wet_flag = 1'b0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(3) == 0) s = 1'($urandom_range(1));
      else s = wet_flag & exc_now();
      step(($urandom_range(249) == 0), ($urandom_range(24) != 0), s);
      if (valid_ref && $urandom_range(2) == 0) wet_flag = !wet_flag;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/moisture_sense_frontend.md
MOISTURE_SENSE_FRONTEND -- requirements
Module: moisture_sense_frontend

Interface
REQ-001 SHALL have parameter EXC_PERIOD, default 8: excitation-off cycles per measurement, minimum 2.
REQ-002 SHALL have parameter SETTLE_CYC, default 4: excitation-on cycles before sampling, minimum 1.
REQ-003 SHALL have parameter DEB_WET, default 3: consecutive wet samples to assert moisture, minimum 1.
REQ-004 SHALL have parameter DEB_DRY, default 5: consecutive dry samples to deassert moisture, minimum 1.
REQ-005 SHALL have port clk, input, 1: the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1: measurement sequencer run enable.
REQ-008 SHALL have port sense_in, input, 1: asynchronous electrode comparator output, 1 = conductive.
REQ-009 SHALL have port exc_drive, output, 1: electrode excitation enable.
REQ-010 SHALL have port exc_polarity, output, 1: excitation polarity; toggles each measurement to prevent electrolysis.
REQ-011 SHALL have port moisture_sensor, output, 1: debounced moisture flag consumed by the charge-enable logic.
REQ-012 SHALL have port sample_valid, output, 1: one-cycle pulse when a measurement completes.
REQ-013 SHALL have port sensor_fault, output, 1: sticky leakage fault.

Function
REQ-014 SHALL synchronize sense_in through a 2-flop synchronizer; all decisions use the synchronized value (sense_s).
REQ-015 SHALL implement the FSM states IDLE, WAIT, SETTLE and SAMPLE.
REQ-016 IDLE: exc_drive=0; go to WAIT when enable=1.
REQ-017 WAIT: exc_drive=0 for exactly EXC_PERIOD cycles; capture sense_s as the baseline on the last cycle; then go to SETTLE.
REQ-018 SETTLE: exc_drive=1 for exactly SETTLE_CYC cycles; then go to SAMPLE.
REQ-019 SAMPLE: exc_drive=1 for one cycle; capture sense_s as the measurement; then go to WAIT.
REQ-020 A full measurement period SHALL be EXC_PERIOD+SETTLE_CYC+1 cycles.
REQ-021 exc_polarity SHALL toggle on each SAMPLE->WAIT transition.
REQ-022 sample_valid SHALL be 1 in the cycle after SAMPLE; moisture_sensor, the debounce counters and sensor_fault SHALL update on that same edge.
REQ-023 Wet sample: increment wet_cnt, saturating at DEB_WET, and clear dry_cnt.
REQ-024 Dry sample: increment dry_cnt, saturating at DEB_DRY, and clear wet_cnt.
REQ-025 moisture_sensor SHALL set when wet_cnt reaches DEB_WET and clear when dry_cnt reaches DEB_DRY; otherwise it holds.
REQ-026 Baseline=1 on two consecutive measurements SHALL set sensor_fault; sensor_fault clears only on reset.
REQ-027 While sensor_fault=1, moisture_sensor SHALL be forced to 1 (fail-safe: charging blocked).
REQ-028 enable=0 in any state SHALL take the FSM to IDLE on the next edge, with exc_drive=0 and the phase counter, wet_cnt and dry_cnt cleared.
REQ-029 enable=0 SHALL NOT change moisture_sensor, sensor_fault or exc_polarity.
REQ-030 enable=0 in the SAMPLE cycle SHALL discard that sample: no sample_valid pulse.
REQ-031 Counter widths SHALL be $clog2 of max(parameter)+1; counters SHALL NOT wrap.

Reset
REQ-032 reset=1 SHALL force on the next edge: FSM=IDLE, exc_drive=0, exc_polarity=0, moisture_sensor=0, sample_valid=0, sensor_fault=0, all counters 0 and synchronizer flops 0.
REQ-033 reset SHALL take priority over enable and over any in-progress measurement.

Structure
REQ-034 FSM state encoding and default parameter values SHALL live in shared package bms_pkg.
REQ-035 The debounce/hysteresis counter pair SHALL be a single sub-module moisture_debounce, instantiated once.

Verification (EXC_PERIOD=8, SETTLE_CYC=4, DEB_WET=3, DEB_DRY=5)
REQ-036 Reset then enable=1, sense_in=0 -> exc_drive high in cycles 9-13 of each 13-cycle period; sample_valid every 13 cycles; moisture_sensor stays 0; exc_polarity alternates.
REQ-037 sense_in=1 only while exc_drive=1 -> moisture_sensor=1 at the 3rd sample_valid; then sense_in=0 -> moisture_sensor=0 at the 5th sample_valid.
REQ-038 Wet, wet, dry, wet, wet samples -> moisture_sensor remains 0 because wet_cnt resets at the dry sample.
REQ-039 sense_in=1 constantly, so baseline is high -> sensor_fault=1 and moisture_sensor=1 at the 2nd sample_valid; enable=0 does not clear either; only reset does.
REQ-040 enable dropped during SETTLE -> exc_drive=0 on the next cycle, no sample_valid; re-enable restarts with a full 8-cycle WAIT.
REQ-041 reset asserted mid-SETTLE with moisture_sensor=1 -> all outputs 0 on the next edge.
